// File: rtl/keccak_lane_feeder.sv
// Keccak rate-block packer with SHA-3 pad10*1 and 25-lane burst replay.
// Build macro LANE_FEEDER_BYTESWAP_EN selects big-endian input words.
module keccak_lane_feeder #(
  parameter int unsigned RATE_LANES = 17,
  parameter logic [7:0]  SUFFIX     = 8'h06
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [3:0]  in_bytes,
  output logic        in_ready,
  input  logic        sink_free,
  output logic [63:0] lane,
  output logic [6:0]  count,
  output logic        blk_last
);
  localparam logic [7:0] RATE_BYTES = 8'(8 * RATE_LANES);
  localparam logic [4:0] WP_LAST    = 5'(RATE_LANES - 1);
  localparam logic [6:0] CNT_IDLE   = 7'd127;
  localparam logic [6:0] CNT_END    = 7'd24;
  localparam logic [6:0] CNT_PRE    = 7'd23;

  typedef enum logic [1:0] {S_FILL, S_PAD, S_WAIT, S_BURST} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_buf [RATE_LANES];
  logic [4:0]  r_wp;
  logic [7:0]  r_L;
  logic        r_pad_pending;
  logic        r_final;
  logic [63:0] r_lane;
  logic [6:0]  r_count;
  logic        r_blk_last;

  logic        w_accept;
  logic [3:0]  w_nbytes;
  logic [7:0]  w_L;
  logic        w_L_full;
  logic [63:0] w_word;
  logic [63:0] w_pad_mask [RATE_LANES];
  logic [6:0]  w_next_idx;
  logic [63:0] w_next_lane;

  assign in_ready = (r_state == S_FILL);
  assign w_accept = in_valid & in_ready;
  assign w_nbytes = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
  assign w_L      = {r_wp, 3'b000} + {4'b0000, w_nbytes};
  assign w_L_full = (w_L >= RATE_BYTES);

  assign lane     = r_lane;
  assign count    = r_count;
  assign blk_last = r_blk_last;

  // Bytes at or beyond the valid count of a last word are zeroed on entry,
  // so the pad stage only has to XOR the suffix and the final 0x80.
  always_comb begin
    w_word = in_data;
`ifdef LANE_FEEDER_BYTESWAP_EN
    for (int unsigned b = 0; b < 8; b++) begin
      w_word[8*b +: 8] = in_data[8*(7-b) +: 8];
    end
`endif
    if (in_last) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (b[3:0] >= w_nbytes) w_word[8*b +: 8] = '0;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < RATE_LANES; i++) begin
      w_pad_mask[i] = '0;
      if (r_L[7:3] == i[4:0]) w_pad_mask[i][{r_L[2:0], 3'b000} +: 8] = SUFFIX;
    end
    w_pad_mask[RATE_LANES-1][63:56] = w_pad_mask[RATE_LANES-1][63:56] ^ 8'h80;
  end

  always_comb begin
    w_next_idx  = (r_state == S_BURST) ? (r_count + 7'd1) : '0;
    w_next_lane = '0;
    for (int unsigned i = 0; i < RATE_LANES; i++) begin
      if (i[6:0] == w_next_idx) w_next_lane = r_buf[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FILL;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_FILL: begin
        if (w_accept) begin
          if (in_last)                w_state_nxt = w_L_full ? S_WAIT : S_PAD;
          else if (r_wp == WP_LAST)   w_state_nxt = S_WAIT;
        end
      end
      S_PAD:   w_state_nxt = S_WAIT;
      S_WAIT:  if (sink_free) w_state_nxt = S_BURST;
      S_BURST: if (r_count == CNT_END) w_state_nxt = r_pad_pending ? S_PAD : S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RATE_LANES; i++) r_buf[i] <= '0;
      r_wp          <= '0;
      r_L           <= '0;
      r_pad_pending <= 1'b0;
      r_final       <= 1'b0;
      r_lane        <= '0;
      r_count       <= CNT_IDLE;
      r_blk_last    <= 1'b0;
    end else begin
      unique case (r_state)
        S_FILL: begin
          if (w_accept) begin
            for (int unsigned i = 0; i < RATE_LANES; i++) begin
              if (i[4:0] == r_wp) r_buf[i] <= w_word;
            end
            r_wp <= r_wp + 5'd1;
            if (in_last) begin
              r_L           <= w_L;
              r_pad_pending <= w_L_full;
            end
          end
        end
        S_PAD: begin
          for (int unsigned i = 0; i < RATE_LANES; i++) r_buf[i] <= r_buf[i] ^ w_pad_mask[i];
          r_final <= 1'b1;
        end
        S_WAIT: begin
          if (sink_free) begin
            r_count <= '0;
            r_lane  <= r_buf[0];
          end
        end
        S_BURST: begin
          if (r_count == CNT_END) begin
            // Buffer is wiped here so a pending pad block starts from all-zero data.
            for (int unsigned i = 0; i < RATE_LANES; i++) r_buf[i] <= '0;
            r_wp       <= '0;
            r_final    <= 1'b0;
            r_count    <= CNT_IDLE;
            r_lane     <= '0;
            r_blk_last <= 1'b0;
            if (r_pad_pending) begin
              r_pad_pending <= 1'b0;
              r_L           <= '0;
            end
          end else begin
            r_count    <= r_count + 7'd1;
            r_lane     <= w_next_lane;
            r_blk_last <= r_final & (r_count == CNT_PRE);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_lane_feeder.sv
// Bench for keccak_lane_feeder: random messages checked against a byte-level
// SHA-3 padding model, plus directed cases with literal expectations.
module tb_keccak_lane_feeder;
  localparam int unsigned R   = 17;
  localparam int unsigned RB  = 8 * R;
  localparam logic [7:0]  SFX = 8'h06;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [3:0]  in_bytes = '0;
  logic        in_ready;
  logic        sink_free = 1'b0;
  logic [63:0] lane;
  logic [6:0]  count;
  logic        blk_last;

  keccak_lane_feeder #(.RATE_LANES(R), .SUFFIX(SFX)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_bytes(in_bytes), .in_ready(in_ready),
    .sink_free(sink_free), .lane(lane), .count(count), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [63:0] lane; bit last; } exp_t;
  exp_t        exp_q[$];
  int          burst_pos = 0;
  int          bursts_seen = 0;
  logic [63:0] cap [8][25];
  bit          cap_last [8];
  bit          sink_rand = 1'b0;
  bit          sink_dir = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Standard SHA-3 padding over the whole message byte string.
  task automatic model_msg(input byte unsigned msg[$]);
    int unsigned n;
    int unsigned nb;
    byte unsigned p[];
    exp_t e;
    n  = msg.size();
    nb = n / RB + 1;
    p  = new[nb * RB];
    foreach (p[k]) p[k] = 8'h00;
    foreach (msg[k]) p[k] = msg[k];
    p[n]         = p[n] ^ SFX;
    p[nb*RB - 1] = p[nb*RB - 1] ^ 8'h80;
    for (int unsigned b = 0; b < nb; b++) begin
      for (int unsigned i = 0; i < 25; i++) begin
        e.lane = '0;
        if (i < R) for (int unsigned k = 0; k < 8; k++) e.lane[8*k +: 8] = p[b*RB + 8*i + k];
        e.last = (b == nb - 1) && (i == 24);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive_word(input logic [63:0] d, input bit last, input logic [3:0] nb);
    bit done;
    done     = 1'b0;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    in_valid = 1'b1;
    for (int t = 0; t < 4000 && !done; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      in_valid = 1'b0;
      $display("FAIL accept_timeout: word not accepted, expected acceptance within 4000 cycles");
    end
  endtask

  task automatic idle_gap(input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_msg(input byte unsigned msg[$], input bit gaps, input bit allow_extra);
    int unsigned n;
    int unsigned nfull;
    int unsigned rem;
    bit          extra0;
    bit          lst;
    logic [63:0] w;
    n      = msg.size();
    nfull  = n / 8;
    rem    = n % 8;
    extra0 = allow_extra && (n != 0) && (rem == 0) && ($urandom_range(0, 1) == 1);
    model_msg(msg);
    for (int unsigned wi = 0; wi < nfull; wi++) begin
      lst = (rem == 0) && !extra0 && (wi == nfull - 1);
      w   = {$urandom, $urandom};
      for (int unsigned k = 0; k < 8; k++) w[8*k +: 8] = msg[8*wi + k];
      idle_gap(gaps);
      drive_word(w, lst, lst ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 15)));
    end
    if (rem != 0) begin
      w = {$urandom, $urandom};
      for (int unsigned k = 0; k < rem; k++) w[8*k +: 8] = msg[8*nfull + k];
      idle_gap(gaps);
      drive_word(w, 1'b1, 4'(rem));
    end else if (n == 0 || extra0) begin
      w = {$urandom, $urandom};
      idle_gap(gaps);
      drive_word(w, 1'b1, 4'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_bursts(input int target);
    int t;
    t = 0;
    while (bursts_seen < target && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    checks++;
    if (bursts_seen < target) begin
      errors++;
      $display("FAIL burst_timeout: saw %0d bursts, expected %0d", bursts_seen, target);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    sink_free = sink_rand ? ($urandom_range(0, 2) != 0) : sink_dir;
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (count != 7'd127) begin
        chk("burst_count", 64'(count), 64'(burst_pos));
        chk("ready_in_burst", 64'(in_ready), 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_burst: count %0d, expected no burst", count);
        end else begin
          e = exp_q.pop_front();
          chk("lane", lane, e.lane);
          chk("blk_last", 64'(blk_last), 64'(e.last));
        end
        cap[bursts_seen % 8][burst_pos] = lane;
        burst_pos++;
        if (burst_pos == 25) begin
          cap_last[bursts_seen % 8] = blk_last;
          bursts_seen++;
          burst_pos = 0;
        end
      end else begin
        if (burst_pos != 0) begin
          checks++;
          errors++;
          $display("FAIL burst_gap: count 127, expected %0d", burst_pos);
          burst_pos = 0;
        end
        chk("idle_blk_last", 64'(blk_last), 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    byte unsigned m[$];
    int           b0;
    int unsigned  n;
    bit           hit;
    int unsigned  lens [14];
    lens = '{0, 1, 7, 8, 127, 128, 134, 135, 136, 137, 143, 144, 271, 272};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd127);
    chk("rst_lane", lane, 64'd0);
    chk("rst_blk_last", 64'(blk_last), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    sink_dir = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Empty message: pure pad block, padded-path latency.
    b0 = bursts_seen;
    m.delete();
    send_msg(m, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("lat_pad_idle", 64'(count), 64'd127);
    @(posedge clk); #1;
    chk("lat_pad_first", 64'(count), 64'd0);
    wait_bursts(b0 + 1);
    chk("empty_lane0", cap[b0 % 8][0], 64'h06);
    chk("empty_lane1", cap[b0 % 8][1], 64'h0);
    chk("empty_lane16", cap[b0 % 8][16], 64'h8000000000000000);
    chk("empty_lane24", cap[b0 % 8][24], 64'h0);
    chk("empty_last", 64'(cap_last[b0 % 8]), 64'd1);

    // 3-byte message "abc".
    b0 = bursts_seen;
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0, 1'b0);
    wait_bursts(b0 + 1);
    chk("abc_lane0", cap[b0 % 8][0], 64'h0000000006636261);
    chk("abc_lane16", cap[b0 % 8][16], 64'h8000000000000000);
    chk("abc_last", 64'(cap_last[b0 % 8]), 64'd1);

    // Exactly one full block with the last flag: data block then pad block.
    b0 = bursts_seen;
    m.delete();
    for (int unsigned k = 0; k < 136; k++) m.push_back(8'(k));
    send_msg(m, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("lat_full_first", 64'(count), 64'd0);
    wait_bursts(b0 + 2);
    chk("full_b0_lane0", cap[b0 % 8][0], 64'h0706050403020100);
    chk("full_b0_lane16", cap[b0 % 8][16], 64'h8786858483828180);
    chk("full_b0_last", 64'(cap_last[b0 % 8]), 64'd0);
    chk("full_b1_lane0", cap[(b0 + 1) % 8][0], 64'h06);
    chk("full_b1_lane16", cap[(b0 + 1) % 8][16], 64'h8000000000000000);
    chk("full_b1_last", 64'(cap_last[(b0 + 1) % 8]), 64'd1);

    // Pad byte lands on the final rate byte.
    b0 = bursts_seen;
    m.delete();
    for (int unsigned k = 0; k < 135; k++) m.push_back(8'(k));
    send_msg(m, 1'b0, 1'b0);
    wait_bursts(b0 + 1);
    chk("p135_lane16", cap[b0 % 8][16], 64'h8686858483828180);
    chk("p135_last", 64'(cap_last[b0 % 8]), 64'd1);

    // sink_free held low in WAIT.
    sink_dir = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_count", 64'(count), 64'd127);
      chk("hold_ready", 64'(in_ready), 64'd0);
    end
    sink_dir = 1'b1;
    @(posedge clk); #1;
    chk("rel_first", 64'(count), 64'd0);
    repeat (24) @(posedge clk);
    #1;
    chk("rel_last_idx", 64'(count), 64'd24);
    @(posedge clk); #1;
    chk("rel_idle", 64'(count), 64'd127);

    // Reset mid-burst, then a clean message.
    m.delete();
    for (int unsigned k = 0; k < 40; k++) m.push_back(8'($urandom));
    send_msg(m, 1'b0, 1'b0);
    hit = 1'b0;
    for (int t = 0; t < 100 && !hit; t++) begin
      @(negedge clk);
      if (count == 7'd12) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL count12_timeout: count 12 not seen, expected within 100 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_count", 64'(count), 64'd127);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    burst_pos = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", 64'(in_ready), 64'd1);
    chk("postrst_count", 64'(count), 64'd127);
    @(posedge clk); #1;
    b0 = bursts_seen;
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0, 1'b0);
    wait_bursts(b0 + 1);
    chk("postrst_lane0", cap[b0 % 8][0], 64'h0000000006636261);
    chk("postrst_lane1", cap[b0 % 8][1], 64'h0);

    // Random messages with random source gaps and sink back-pressure.
    sink_rand = 1'b1;
    for (int unsigned mi = 0; mi < 40; mi++) begin
      if ($urandom_range(0, 3) == 0) n = lens[$urandom_range(0, 13)];
      else                           n = $urandom_range(0, 350);
      m.delete();
      for (int unsigned k = 0; k < n; k++) m.push_back(8'($urandom));
      send_msg(m, 1'b1, 1'b1);
    end
    hit = 1'b0;
    for (int t = 0; t < 5000 && !hit; t++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && burst_pos == 0) hit = 1'b1;
    end
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
    sink_rand = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
